// File: rtl/dvma_mem_arbiter_if.sv
// dvma_mem_arbiter_if
//   Bundles the request, status and acknowledge signals shared between the
//   memory arbiter and the logic around it: the DVMA decoder, the CPU cycle
//   logic and the DRAM/parity controller.
//
//   Request side (driven by the master modport):
//     cpu_req, dvma_req, dvma_wr, en_dvma, proterr, parerr
//   Arbiter side (driven by the slave modport, which is the arbiter itself):
//     aen, xen, cyc[CW-1:0], c_s7, mem_start, cpu_ack, xack, dvma_err,
//     last_owner
interface dvma_mem_arbiter_if #(
    parameter int CW = 3
);
    logic          cpu_req;
    logic          dvma_req;
    logic          dvma_wr;
    logic          en_dvma;
    logic          proterr;
    logic          parerr;

    logic          aen;
    logic          xen;
    logic [CW-1:0] cyc;
    logic          c_s7;
    logic          mem_start;
    logic          cpu_ack;
    logic          xack;
    logic          dvma_err;
    logic          last_owner;

    modport master (
        output cpu_req, dvma_req, dvma_wr, en_dvma, proterr, parerr,
        input  aen, xen, cyc, c_s7, mem_start, cpu_ack, xack, dvma_err,
               last_owner
    );

    modport slave (
        input  cpu_req, dvma_req, dvma_wr, en_dvma, proterr, parerr,
        output aen, xen, cyc, c_s7, mem_start, cpu_ack, xack, dvma_err,
               last_owner
    );
endinterface

// File: rtl/dvma_mem_arbiter.sv
// dvma_mem_arbiter
//   Clocked arbiter that hands the on-board memory/parity datapath either to
//   the 68010 CPU or to a Multibus DVMA master. It runs the memory-cycle
//   state counter, acknowledges the CPU at the end of its cycle, and keeps
//   the Multibus acknowledge up until the Multibus command drops.
//
//   Ports:
//     clk    - system clock
//     reset  - synchronous, active-high
//     bus    - dvma_mem_arbiter_if.slave: requests and error inputs in,
//              ownership enables, cycle counter and acknowledges out
//
//   Parameters:
//     MEM_STATES   - clocks per memory cycle (2..16)
//     CW           - width of the cycle counter, 2**CW >= MEM_STATES
//     HOLD_TIMEOUT - clocks allowed in DVMA_HOLD before a forced release
module dvma_mem_arbiter #(
    parameter int MEM_STATES   = 8,
    parameter int CW           = 3,
    parameter int HOLD_TIMEOUT = 64
) (
    input logic               clk,
    input logic               reset,
    dvma_mem_arbiter_if.slave bus
);

    localparam int HW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam logic [CW-1:0] CYC_LAST  = CW'(MEM_STATES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CPU_RUN,
        DVMA_RUN,
        DVMA_HOLD,
        TURN
    } state_t;

    state_t        state;
    logic          aen_q;
    logic          xen_q;
    logic [CW-1:0] cyc_q;
    logic          c_s7_q;
    logic          mem_start_q;
    logic          cpu_ack_q;
    logic          xack_q;
    logic          dvma_err_q;
    logic          last_owner_q;
    logic          wr_latched;
    logic          req_dropped;
    logic [HW-1:0] hold_cnt;

    logic          dvma_valid;
    logic          dvma_fault;
    logic [CW-1:0] cyc_inc;
    logic          cyc_inc_last;

    assign dvma_valid   = bus.dvma_req & bus.en_dvma;
    // Parity is only meaningful when memory was read back to the master.
    assign dvma_fault   = bus.proterr | (bus.parerr & ~wr_latched);
    assign cyc_inc      = cyc_q + 1'b1;
    assign cyc_inc_last = (cyc_inc == CYC_LAST);

    // Single registered FSM: every output is a flop updated here, so the
    // outputs never glitch and the exclusivity of aen/xen is structural
    // (each is only ever set when entering its own RUN state).
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            aen_q        <= 1'b0;
            xen_q        <= 1'b0;
            cyc_q        <= '0;
            c_s7_q       <= 1'b0;
            mem_start_q  <= 1'b0;
            cpu_ack_q    <= 1'b0;
            xack_q       <= 1'b0;
            dvma_err_q   <= 1'b0;
            last_owner_q <= 1'b1;
            wr_latched   <= 1'b0;
            req_dropped  <= 1'b0;
            hold_cnt     <= '0;
        end else begin
            mem_start_q <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dvma_err_q  <= 1'b0;

            case (state)
                IDLE: begin
                    cyc_q  <= '0;
                    c_s7_q <= 1'b0;
                    // Contention goes to whoever did not own memory last.
                    if (bus.cpu_req && (!dvma_valid || last_owner_q)) begin
                        state        <= CPU_RUN;
                        aen_q        <= 1'b1;
                        mem_start_q  <= 1'b1;
                        last_owner_q <= 1'b0;
                    end else if (dvma_valid) begin
                        state        <= DVMA_RUN;
                        xen_q        <= 1'b1;
                        mem_start_q  <= 1'b1;
                        last_owner_q <= 1'b1;
                        wr_latched   <= bus.dvma_wr;
                        req_dropped  <= 1'b0;
                    end
                end

                CPU_RUN: begin
                    if (cyc_q == CYC_LAST) begin
                        state  <= TURN;
                        aen_q  <= 1'b0;
                        cyc_q  <= '0;
                        c_s7_q <= 1'b0;
                    end else begin
                        cyc_q     <= cyc_inc;
                        c_s7_q    <= cyc_inc_last;
                        cpu_ack_q <= cyc_inc_last;
                    end
                end

                DVMA_RUN: begin
                    // The DRAM cycle cannot be aborted, so a dropped request
                    // is only remembered and acted on at the terminal state.
                    if (cyc_q == CYC_LAST) begin
                        cyc_q    <= '0;
                        c_s7_q   <= 1'b0;
                        hold_cnt <= '0;
                        if (req_dropped || !bus.dvma_req) begin
                            state <= TURN;
                            xen_q <= 1'b0;
                        end else begin
                            state      <= DVMA_HOLD;
                            xack_q     <= ~dvma_fault;
                            dvma_err_q <= dvma_fault;
                        end
                    end else begin
                        cyc_q  <= cyc_inc;
                        c_s7_q <= cyc_inc_last;
                        if (!bus.dvma_req) begin
                            req_dropped <= 1'b1;
                        end
                    end
                end

                DVMA_HOLD: begin
                    // Wait for the Multibus command to drop; a master that
                    // never lets go is released by force and flagged.
                    if (!bus.dvma_req) begin
                        state  <= TURN;
                        xen_q  <= 1'b0;
                        xack_q <= 1'b0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state      <= TURN;
                        xen_q      <= 1'b0;
                        xack_q     <= 1'b0;
                        dvma_err_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                TURN: begin
                    state <= IDLE;
                end

                default: begin
                    state  <= IDLE;
                    aen_q  <= 1'b0;
                    xen_q  <= 1'b0;
                    xack_q <= 1'b0;
                    cyc_q  <= '0;
                    c_s7_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.aen        = aen_q;
    assign bus.xen        = xen_q;
    assign bus.cyc        = cyc_q;
    assign bus.c_s7       = c_s7_q;
    assign bus.mem_start  = mem_start_q;
    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.xack       = xack_q;
    assign bus.dvma_err   = dvma_err_q;
    assign bus.last_owner = last_owner_q;

endmodule

// File: tb/tb_dvma_mem_arbiter.sv
// tb_dvma_mem_arbiter
//   Drives the arbiter transaction by transaction. For every transaction the
//   expected waveform is worked out from the arbitration rules with plain
//   arithmetic (grant winner, run length, hold length, release cycle) and
//   compared against the DUT in every clock after the grant.
module tb_dvma_mem_arbiter;

    localparam int MS = 8;
    localparam int CW = 3;
    localparam int HT = 4;

    typedef struct packed {
        logic          aen;
        logic          xen;
        logic [CW-1:0] cyc;
        logic          c_s7;
        logic          mem_start;
        logic          cpu_ack;
        logic          xack;
        logic          dvma_err;
        logic          last_owner;
    } out_t;

    logic clk = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;
    bit model_last = 1'b1;

    always #5 clk = ~clk;

    dvma_mem_arbiter_if #(.CW(CW)) bus ();

    dvma_mem_arbiter #(
        .MEM_STATES  (MS),
        .CW          (CW),
        .HOLD_TIMEOUT(HT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    function automatic bit rbit();
        return 1'($urandom);
    endfunction

    // Outputs of a cycle with nobody owning memory.
    function automatic out_t idle_out();
        out_t o;
        o = '0;
        o.last_owner = model_last;
        return o;
    endfunction

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit cpu, input bit dreq, input bit en,
                                 input bit wr, input bit par, input bit prot);
        bus.cpu_req  = cpu;
        bus.dvma_req = dreq;
        bus.en_dvma  = en;
        bus.dvma_wr  = wr;
        bus.parerr   = par;
        bus.proterr  = prot;
    endtask

    task automatic checkOutput(input string tag, input out_t exp);
        out_t obs;
        obs = '{aen: bus.aen, xen: bus.xen, cyc: bus.cyc, c_s7: bus.c_s7,
                mem_start: bus.mem_start, cpu_ack: bus.cpu_ack,
                xack: bus.xack, dvma_err: bus.dvma_err,
                last_owner: bus.last_owner};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b (aen xen cyc c_s7 mem_start cpu_ack xack dvma_err last_owner)",
                   tag, obs, exp);
        end
        checks++;
        assert ((bus.aen & bus.xen) === 1'b0) else begin
            errors++;
            $error("[TB] FAIL %s exclusive: aen=%b xen=%b required not both 1",
                   tag, bus.aen, bus.xen);
        end
    endtask

    // One arbitration round starting in an IDLE cycle (cycle 0). req_last is
    // the last cycle in which the DVMA master keeps dvma_req high (at most
    // MS+HT so the round closes on its own); par_m/prot_m are the error
    // inputs presented in the terminal cycle. other_hi keeps the request of
    // the non-winner asserted throughout instead of random noise.
    task automatic run_txn(input string tag, input bit want_cpu,
                           input bit want_dvma, input bit en, input bit wr,
                           input int req_last, input bit par_m,
                           input bit prot_m, input bit other_hi);
        bit   dv_valid;
        bit   to_dvma;
        bit   err;
        bit   held;
        bit   forced;
        int   hold_end;
        int   turn;
        out_t exp;

        dv_valid = want_dvma && en;
        err      = 1'b0;

        if (!want_cpu && !dv_valid) begin
            applyStimulus(1'b0, want_dvma, en, rbit(), rbit(), rbit());
            for (int k = 1; k <= 3; k++) begin
                tick();
                checkOutput($sformatf("%s idle k=%0d", tag, k), idle_out());
            end
            return;
        end

        to_dvma    = dv_valid && (!want_cpu || !model_last);
        model_last = to_dvma;

        held     = to_dvma && (req_last >= MS);
        forced   = held && (req_last >= MS + HT);
        hold_end = held ? ((req_last + 1 < MS + HT) ? req_last + 1 : MS + HT) : MS;
        turn     = to_dvma ? hold_end + 1 : MS + 1;

        applyStimulus(want_cpu, want_dvma, en, wr, rbit(), rbit());

        for (int k = 1; k <= turn + 1; k++) begin
            tick();
            exp = '0;
            exp.last_owner = model_last;
            if (k <= MS) begin
                exp.aen       = !to_dvma;
                exp.xen       = to_dvma;
                exp.cyc       = CW'(k - 1);
                exp.mem_start = (k == 1);
                exp.c_s7      = (k == MS);
                exp.cpu_ack   = !to_dvma && (k == MS);
            end else if (held && k <= hold_end) begin
                exp.xen      = 1'b1;
                exp.xack     = !err;
                exp.dvma_err = err && (k == MS + 1);
            end else if (k == turn) begin
                exp.dvma_err = forced;
            end
            checkOutput($sformatf("%s k=%0d", tag, k), exp);

            if (k <= turn) begin
                if (to_dvma) begin
                    bit par;
                    bit prot;
                    bit wr_now;
                    par    = (k == MS) ? par_m  : rbit();
                    prot   = (k == MS) ? prot_m : rbit();
                    wr_now = rbit();
                    applyStimulus(other_hi ? 1'b1 : rbit(), k <= req_last,
                                  rbit(), wr_now, par, prot);
                    if (k == MS) begin
                        err = prot_m | (par_m & ~wr);
                    end
                end else begin
                    applyStimulus(k <= MS, other_hi ? 1'b1 : rbit(), rbit(),
                                  rbit(), rbit(), rbit());
                end
            end
        end
    endtask

    initial begin
        out_t exp;

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        model_last = 1'b1;
        checkOutput("reset values", idle_out());
        reset = 1'b0;
        tick();
        checkOutput("idle after reset", idle_out());

        run_txn("cpu_only", 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        run_txn("dvma_read", 1'b0, 1'b1, 1'b1, 1'b0, 11, 1'b0, 1'b0, 1'b0);
        run_txn("dvma_read_parerr", 1'b0, 1'b1, 1'b1, 1'b0, MS + 2, 1'b1, 1'b0, 1'b0);
        run_txn("dvma_write_parerr", 1'b0, 1'b1, 1'b1, 1'b1, MS + 2, 1'b1, 1'b0, 1'b0);
        run_txn("dvma_write_proterr", 1'b0, 1'b1, 1'b1, 1'b1, MS + 1, 1'b0, 1'b1, 1'b0);
        run_txn("dvma_early_drop", 1'b0, 1'b1, 1'b1, 1'b0, 3, 1'b1, 1'b1, 1'b0);
        run_txn("hold_timeout", 1'b0, 1'b1, 1'b1, 1'b0, MS + HT, 1'b0, 1'b0, 1'b0);
        run_txn("regrant_after_timeout", 1'b0, 1'b1, 1'b1, 1'b0, MS, 1'b0, 1'b0, 1'b0);
        run_txn("en_dvma_off", 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a DVMA run, at cyc == 3.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        model_last = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp = '0;
            exp.xen        = 1'b1;
            exp.cyc        = CW'(k - 1);
            exp.mem_start  = (k == 1);
            exp.last_owner = 1'b1;
            checkOutput($sformatf("pre_reset k=%0d", k), exp);
        end
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("mid_run reset", idle_out());
        reset = 1'b0;
        tick();
        checkOutput("idle after mid_run reset", idle_out());

        run_txn("contend1_cpu", 1'b1, 1'b1, 1'b1, 1'b0, MS + 1, 1'b0, 1'b0, 1'b1);
        run_txn("contend2_dvma", 1'b1, 1'b1, 1'b1, 1'b0, MS + 1, 1'b0, 1'b0, 1'b1);
        run_txn("contend3_cpu", 1'b1, 1'b1, 1'b1, 1'b0, MS + 1, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            run_txn($sformatf("rand%0d", i), rbit(), rbit(),
                    $urandom_range(3, 0) != 0, rbit(),
                    int'($urandom_range(MS + HT, 0)), rbit(), rbit(), rbit());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dvma_mem_arbiter.md
Name: dvma_mem_arbiter

Overview:
- Synchronous arbiter that shares the on-board memory/parity datapath between the 68010 CPU and Multibus DVMA masters.
- Produces the ownership enables `aen` (CPU) and `xen` (DVMA) and the memory-cycle state counter with its terminal state `c_s7`.
- Generates the Multibus acknowledge (`xack`) and the CPU acknowledge.
- Sits between the DVMA address/strobe decoder, the CPU cycle logic and the DRAM/parity controller, and replaces the asynchronous ownership handoff with a clocked FSM.

Parameters:
- MEM_STATES, 8: clock cycles per memory cycle; counter runs 0..MEM_STATES-1. Legal range 2..16.
- CW, 3: counter width; must satisfy 2^CW >= MEM_STATES.
- HOLD_TIMEOUT, 64: maximum cycles in DVMA_HOLD waiting for the Multibus command to drop before forced release.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high.
- cpu_req, input, 1: CPU memory cycle request. Level; must drop in the cycle after `cpu_ack`.
- dvma_req, input, 1: decoded DVMA request (`xreq`). Level; held until the Multibus command drops.
- dvma_wr, input, 1: DVMA cycle is a write. Sampled at grant.
- en_dvma, input, 1: DVMA enabled.
- proterr, input, 1: protection error. Sampled at `c_s7`.
- parerr, input, 1: parity error. Sampled at `c_s7`; applies to reads only.
- aen, output, 1: CPU owns memory.
- xen, output, 1: DVMA owns memory.
- cyc, output, CW: memory cycle state.
- c_s7, output, 1: `cyc == MEM_STATES-1` while an owner is active.
- mem_start, output, 1: one-cycle pulse in the first cycle of ownership.
- cpu_ack, output, 1: one-cycle CPU completion pulse.
- xack, output, 1: Multibus acknowledge. Level.
- dvma_err, output, 1: one-cycle pulse on a DVMA error or forced release.
- last_owner, output, 1: 0 = CPU, 1 = DVMA. Indicates the owner of the most recent grant.

Behaviour:
- **Reset values:** state IDLE; `aen`, `xen`, `mem_start`, `cpu_ack`, `xack`, `dvma_err`, `c_s7` = 0; `cyc` = 0; `last_owner` = 1, so the CPU wins the first contention. Reset mid-operation aborts the cycle with no ack of either kind.
- **States:** IDLE, CPU_RUN, DVMA_RUN, DVMA_HOLD, TURN. All outputs are registered.
- **IDLE arbitration:**
  - Valid DVMA request = `dvma_req & en_dvma`.
  - CPU only -> CPU_RUN. DVMA only -> DVMA_RUN.
  - Both requesting -> grant goes to the requester that is not `last_owner` (alternating).
  - Neither requesting -> stay in IDLE.
  - On a grant, `last_owner` updates and `dvma_wr` is latched.
- **Grant timing:**
  - Request seen in IDLE at edge N -> `aen` or `xen` = 1 and `mem_start` = 1 from cycle N+1.
  - `cyc` = 0 in cycle N+1 and increments by 1 per cycle.
  - `c_s7` = 1 when `cyc == MEM_STATES-1`.
- **CPU_RUN:**
  - `cpu_ack` pulses in the `c_s7` cycle.
  - Next state TURN.
  - `aen` is held through the `c_s7` cycle.
- **DVMA_RUN:**
  - Error at `c_s7` = `proterr | (parerr & ~dvma_wr_latched)`.
  - In the `c_s7` cycle with no error and `dvma_req` still high: `xack` = 1 from the next cycle, next state DVMA_HOLD.
  - With error: `xack` stays 0, `dvma_err` pulses, next state DVMA_HOLD.
  - If `dvma_req` dropped earlier in the cycle: the memory cycle still runs to `c_s7` (it cannot be aborted); no `xack`, no `dvma_err`; next state TURN.
- **DVMA_HOLD:**
  - `xen` and `xack` are held.
  - When `dvma_req` goes low: `xack` = 0 and `xen` = 0 on the next edge, then TURN.
  - A hold counter starts at 0; if it reaches HOLD_TIMEOUT-1 while `dvma_req` is still high: forced release, `dvma_err` pulses, `xack` = 0, `xen` = 0, next state TURN.
  - After a forced release, a still-high `dvma_req` is treated as a new request.
- **TURN:**
  - Exactly one cycle with `aen` = `xen` = 0 and `cyc` = 0 (dead cycle between owners).
  - Next state IDLE; no arbitration occurs in TURN.
- **en_dvma deasserted:**
  - Blocks new DVMA grants only.
  - A DVMA_RUN or DVMA_HOLD already in progress completes normally.
- **Exclusivity:** `aen` and `xen` are never both 1.
- **Counter wrap:** `cyc` never exceeds MEM_STATES-1 and is forced to 0 outside the RUN states.

Test Plan:
1. **CPU only (MEM_STATES=8):** `cpu_req`=1 at cycle 0 -> `aen`=1 and `mem_start` in cycle 1; `cyc` 0..7 over cycles 1..8; `c_s7` and `cpu_ack` in cycle 8; TURN in cycle 9; IDLE in cycle 10.
2. **DVMA read, no error:** `dvma_req`=1, `en_dvma`=1, `dvma_wr`=0 -> `xen` from cycle 1; `c_s7` in cycle 8; `xack`=1 from cycle 9. Drop `dvma_req` at cycle 12 -> `xack` and `xen` = 0 at cycle 13; TURN.
3. **Contention after reset:** `cpu_req` and `dvma_req` both asserted continuously -> grants alternate CPU, DVMA, CPU; `aen`/`xen` never overlap; one dead TURN cycle plus one IDLE cycle between owners.
4. **Errors:**
   - DVMA read with `parerr`=1 at `c_s7` -> `dvma_err` pulse, `xack` never asserts.
   - DVMA write with `parerr`=1, `proterr`=0 -> `xack` asserts (parity is ignored on writes).
5. **Hold timeout:** HOLD_TIMEOUT=4 and `dvma_req` held high -> `dvma_err` pulse and `xen`=0 four cycles after entering DVMA_HOLD.
6. **Reset and enable:**
   - `reset`=1 mid-DVMA_RUN at `cyc`=3 -> next cycle all outputs at reset values.
   - `en_dvma`=0 with `dvma_req`=1 -> no grant issued.
